// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared mode encodings, defaults and limits for the multi-channel clock divider
package clkdiv_pkg;
  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;
  localparam int MAX_CHANNELS = 8;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_RST_DIV = 0;
  localparam bit DEF_RST_MODE = 1'b0;
  function automatic logic is_boundary(mode_e m, logic out);
    return m == MODE_PULSE || out;
  endfunction
endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: control and output bundle of the multi-channel clock divider
interface clkdiv_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH = clkdiv_pkg::DEF_WIDTH
);
  logic [CHANNELS*WIDTH-1:0] div;
  logic [CHANNELS-1:0] mode;
  logic [CHANNELS-1:0] div_wr;
  logic [CHANNELS-1:0] en;
  logic sync;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] pend;
  modport master (output div, mode, div_wr, en, sync, input out, tc, pend);
  modport slave (input div, mode, div_wr, en, sync, output out, tc, pend);
endinterface

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with down-counter, shadowed divisor and period-boundary update
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RST_DIV = DEF_RST_DIV,
  parameter bit RST_MODE = DEF_RST_MODE
) (
  input  logic CLK,
  input  logic nRST,
  input  logic [WIDTH-1:0] div,
  input  logic mode,
  input  logic div_wr,
  input  logic en,
  input  logic sync,
  output logic out,
  output logic tc,
  output logic pend
);
  localparam logic [WIDTH-1:0] RDIV = WIDTH'(RST_DIV);
  localparam mode_e RMODE = mode_e'(RST_MODE);
  logic [WIDTH-1:0] cnt, act_div, shd_div, cnt_n, act_div_n, shd_div_n;
  mode_e act_mode, shd_mode, act_mode_n, shd_mode_n;
  logic out_n, tc_n, pend_n, hit, halt, apply;
  // next state: halt (disable/sync) restarts the period, terminal count reloads, shadow lands on boundaries
  always_comb begin
    hit = cnt == '0;
    halt = !en || sync;
    apply = halt || (hit && is_boundary(act_mode, out));
    cnt_n = apply ? shd_div : hit ? act_div : cnt - WIDTH'(1);
    out_n = halt ? 1'b0 : hit ? (act_mode == MODE_PULSE || !out) : (act_mode == MODE_TOGGLE && out);
    tc_n = !halt && hit;
    act_div_n = apply ? shd_div : act_div;
    act_mode_n = apply ? shd_mode : act_mode;
    shd_div_n = div_wr ? div : shd_div;
    shd_mode_n = div_wr ? mode_e'(mode) : shd_mode;
    pend_n = div_wr || (pend && !apply);
  end
  // channel state register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= RDIV;
      act_div <= RDIV;
      shd_div <= RDIV;
      act_mode <= RMODE;
      shd_mode <= RMODE;
      out <= 1'b0;
      tc <= 1'b0;
      pend <= 1'b0;
    end else begin
      cnt <= cnt_n;
      act_div <= act_div_n;
      shd_div <= shd_div_n;
      act_mode <= act_mode_n;
      shd_mode <= shd_mode_n;
      out <= out_n;
      tc <= tc_n;
      pend <= pend_n;
    end
  end
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock divider with shared realign strobe
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int RST_DIV = DEF_RST_DIV,
  parameter bit RST_MODE = DEF_RST_MODE
) (
  input logic CLK,
  input logic nRST,
  clkdiv_multi_if.slave bus
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    clkdiv_chan #(
      .WIDTH(WIDTH),
      .RST_DIV(RST_DIV),
      .RST_MODE(RST_MODE)
    ) u_chan (
      .CLK(CLK),
      .nRST(nRST),
      .div(bus.div[c*WIDTH +: WIDTH]),
      .mode(bus.mode[c]),
      .div_wr(bus.div_wr[c]),
      .en(bus.en[c]),
      .sync(bus.sync),
      .out(bus.out[c]),
      .tc(bus.tc[c]),
      .pend(bus.pend[c])
    );
  end
endmodule
